watchdog_reset_ctrl: RTL
========================

Name: watchdog_reset_ctrl

Overview:
- Sits directly downstream of the watchdog timer and consumes its level `timeout` output.
- On timeout it first raises a warning interrupt and opens a grace window for software to acknowledge.
- If software does not acknowledge in time, it issues a timed system-reset pulse and re-arms the watchdog.
- It counts escalations and locks the system in reset after too many of them.

Parameters:
- GRACE_CYCLES, 16, number of cycles the WARN state lasts without acknowledge (1..255).
- RST_PULSE, 8, number of cycles `sys_rst` is asserted per escalation (1..255).
- MAX_RESETS, 3, escalation count at which the block enters lockout (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- timeout  input  1  level timeout from the watchdog timer.
- irq_ack  input  1  software acknowledge, single-cycle pulse or level.
- count_clr  input  1  clears `reset_count`; honoured in IDLE only.
- wdt_irq  output  1  warning interrupt, high while in WARN.
- wdt_clear  output  1  kick to the watchdog, high in CLEAR and RESET.
- sys_rst  output  1  active-high system reset request, high in RESET and LOCKED.
- lockout  output  1  high in LOCKED.
- reset_count  output  4  saturating count of escalations.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- General:
  - All outputs are decoded from registered state and counters only (Moore); no combinational path from inputs to outputs.
  - State encoding: IDLE=0, WARN=1, CLEAR=2, RESET=3, LOCKED=4.
- Reset (rst_n low, async):
  - state IDLE; grace and pulse counters 0; reset_count 0.
  - All outputs 0, including state_o.
  - rst_n asserted mid-WARN, mid-RESET or in LOCKED aborts immediately to IDLE; nothing persists.
- IDLE:
  - timeout sampled 1 at an edge -> WARN at that edge; grace_cnt loaded 0.
  - wdt_irq is high starting the following cycle.
  - count_clr sampled 1 in IDLE -> reset_count 0 at that edge. If timeout is also 1 at that edge, both actions apply.
- WARN:
  - grace_cnt increments each cycle.
  - irq_ack sampled 1 -> CLEAR; reset_count unchanged.
  - No ack and grace_cnt == GRACE_CYCLES-1 -> RESET. At that edge reset_count increments, saturating at 15, and pulse_cnt is loaded 0.
  - WARN therefore lasts exactly GRACE_CYCLES cycles without ack.
  - irq_ack on the final grace cycle: ack wins, go to CLEAR, no escalation.
  - timeout dropping during WARN does not leave WARN; only ack or expiry exits.
- CLEAR:
  - wdt_clear=1.
  - Stay while timeout=1; timeout sampled 0 -> IDLE.
  - Minimum residency is 1 cycle.
- RESET:
  - sys_rst=1 and wdt_clear=1; pulse_cnt increments each cycle.
  - On pulse_cnt == RST_PULSE-1:
    - if reset_count >= MAX_RESETS -> LOCKED;
    - otherwise -> CLEAR.
  - sys_rst is high for exactly RST_PULSE cycles when not locking.
- LOCKED:
  - sys_rst=1, lockout=1, wdt_clear=0.
  - Exit only via rst_n.
  - All inputs are ignored.
- Inputs outside their active states:
  - irq_ack outside WARN is ignored.
  - count_clr outside IDLE is ignored.
- Counter widths:
  - grace_cnt and pulse_cnt are 8 bits and compare by equality only.
  - reset_count is 4 bits, saturating and never wrapping.

Test Plan:
- Reset, then timeout=1 at cycle 10, irq_ack pulse at cycle 14 -> wdt_irq high cycles 11–14, state CLEAR, wdt_clear high until timeout drops, then IDLE. reset_count=0, sys_rst never high.
- Timeout held with no ack (GRACE_CYCLES=16, RST_PULSE=8) -> wdt_irq high exactly 16 cycles, then sys_rst and wdt_clear high exactly 8 cycles. reset_count=1, then CLEAR->IDLE once timeout=0.
- Three unacknowledged escalations with MAX_RESETS=3 -> the third RESET is followed by LOCKED. sys_rst stays high and lockout=1 indefinitely. irq_ack and count_clr have no effect; rst_n low returns everything to 0.
- irq_ack on the exact final grace cycle -> CLEAR, no sys_rst pulse, reset_count unchanged.
- count_clr asserted in WARN, then in IDLE, after reset_count=2 -> the WARN assertion is ignored and the IDLE assertion clears reset_count to 0 on the next edge.
- rst_n asserted low asynchronously mid-RESET (pulse_cnt=3) -> sys_rst, wdt_clear, state_o and reset_count drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/watchdog_reset_ctrl.sv
// ---------------------------------------------------------------------------
// watchdog_reset_ctrl
//
// Escalation controller placed behind a watchdog timer. A timeout first
// raises a warning interrupt and opens a grace window for software to
// acknowledge. Without an acknowledge it requests a timed system reset and
// kicks the watchdog. After MAX_RESETS escalations it locks the system in
// reset until rst_n is asserted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   timeout      level timeout from the watchdog timer
//   irq_ack      software acknowledge (pulse or level), honoured in WARN
//   count_clr    clears reset_count, honoured in IDLE
//   wdt_irq      warning interrupt, high in WARN
//   wdt_clear    watchdog kick, high in CLEAR and RESET
//   sys_rst      system reset request, high in RESET and LOCKED
//   lockout      high in LOCKED
//   reset_count  saturating escalation count
//   state_o      current state encoding (debug)
// ---------------------------------------------------------------------------
module watchdog_reset_ctrl #(
  parameter int unsigned GRACE_CYCLES = 16,
  parameter int unsigned RST_PULSE    = 8,
  parameter int unsigned MAX_RESETS   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timeout,
  input  logic       irq_ack,
  input  logic       count_clr,
  output logic       wdt_irq,
  output logic       wdt_clear,
  output logic       sys_rst,
  output logic       lockout,
  output logic [3:0] reset_count,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARN   = 3'd1,
    CLEAR  = 3'd2,
    RESET  = 3'd3,
    LOCKED = 3'd4
  } state_t;

  localparam logic [7:0] GRACE_LAST = 8'(GRACE_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(RST_PULSE - 1);
  localparam logic [3:0] MAX_COUNT  = 4'(MAX_RESETS);

  state_t     state_q, state_d;
  logic [7:0] graceCnt_q, graceCnt_d;
  logic [7:0] pulseCnt_q, pulseCnt_d;
  logic [3:0] resetCount_q, resetCount_d;

  // State and counter registers; rst_n aborts any activity immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      graceCnt_q   <= 8'd0;
      pulseCnt_q   <= 8'd0;
      resetCount_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      graceCnt_q   <= graceCnt_d;
      pulseCnt_q   <= pulseCnt_d;
      resetCount_q <= resetCount_d;
    end
  end

  // Next-state logic. In WARN the acknowledge is tested before expiry so an
  // ack on the final grace cycle still avoids escalation.
  always_comb begin
    state_d      = state_q;
    graceCnt_d   = graceCnt_q;
    pulseCnt_d   = pulseCnt_q;
    resetCount_d = resetCount_q;
    unique case (state_q)
      IDLE: begin
        if (count_clr) begin
          resetCount_d = 4'd0;
        end
        if (timeout) begin
          state_d    = WARN;
          graceCnt_d = 8'd0;
        end
      end
      WARN: begin
        graceCnt_d = graceCnt_q + 8'd1;
        if (irq_ack) begin
          state_d = CLEAR;
        end else if (graceCnt_q == GRACE_LAST) begin
          state_d    = RESET;
          pulseCnt_d = 8'd0;
          if (resetCount_q != 4'hF) begin
            resetCount_d = resetCount_q + 4'd1;
          end
        end
      end
      CLEAR: begin
        if (!timeout) begin
          state_d = IDLE;
        end
      end
      RESET: begin
        pulseCnt_d = pulseCnt_q + 8'd1;
        if (pulseCnt_q == PULSE_LAST) begin
          state_d = (resetCount_q >= MAX_COUNT) ? LOCKED : CLEAR;
        end
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from registered state only.
  assign wdt_irq     = (state_q == WARN);
  assign wdt_clear   = (state_q == CLEAR) || (state_q == RESET);
  assign sys_rst     = (state_q == RESET) || (state_q == LOCKED);
  assign lockout     = (state_q == LOCKED);
  assign reset_count = resetCount_q;
  assign state_o     = state_q;

endmodule
